// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types, width helpers and defaults for the key conditioner
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG
  } hold_state_t;

  localparam int DEF_N_KEYS       = 4;
  localparam int DEF_CNT_MAX      = 20'hF_FFFF;
  localparam int DEF_ACTIVE_LOW   = 0;
  localparam int DEF_TICK_DIV     = 100_000;
  localparam int DEF_LONG_TICKS   = 1000;
  localparam int DEF_REPEAT_TICKS = 200;
  localparam int DEF_REPEAT_EN    = 1;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int hold_width(input int a, input int b);
    return cnt_width((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchroniser, debounce counter, edges and hold FSM
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int CNT_MAX      = DEF_CNT_MAX,
  parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int REPEAT_EN    = DEF_REPEAT_EN
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_raw,
  input  logic tick,
  output logic key_level,
  output logic key_posedge,
  output logic key_negedge,
  output logic key_long,
  output logic key_repeat
);

  localparam int   CW  = cnt_width(CNT_MAX);
  localparam int   HW  = hold_width(LONG_TICKS, REPEAT_TICKS);
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic RPT = (REPEAT_EN != 0);

  logic          p;
  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold_cnt;
  hold_state_t   state;
  logic          upd;
  logic          press_upd;
  logic          release_upd;

  assign p = key_raw ^ INV;

  always_comb begin
    upd         = (cnt == CW'(CNT_MAX)) && (s2 != key_level);
    press_upd   = upd && s2;
    release_upd = upd && !s2;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_posedge <= 1'b0;
      key_negedge <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
      hold_cnt    <= '0;
      state       <= IDLE;
    end else begin
      s1 <= p;
      s2 <= s1;
      if (s1 != s2) begin
        cnt <= '0;
      end else if (cnt != CW'(CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end

      key_posedge <= press_upd;
      key_negedge <= release_upd;
      if (upd) begin
        key_level <= s2;
      end

      key_long   <= 1'b0;
      key_repeat <= 1'b0;
      // Release is checked before tick so a coinciding tick never pulses.
      case (state)
        IDLE: begin
          if (press_upd) begin
            state    <= HELD;
            hold_cnt <= '0;
          end
        end
        HELD: begin
          if (release_upd) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (tick) begin
            if (hold_cnt == HW'(LONG_TICKS - 1)) begin
              key_long <= 1'b1;
              hold_cnt <= '0;
              state    <= LONG;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        LONG: begin
          if (release_upd) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (tick) begin
            if (hold_cnt == HW'(REPEAT_TICKS - 1)) begin
              key_repeat <= RPT;
              hold_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_bank.sv
// rtl/key_debounce_bank.sv - multi-channel key conditioner with a shared hold-tick prescaler
module key_debounce_bank
  import key_pkg::*;
#(
  parameter int N_KEYS       = DEF_N_KEYS,
  parameter int CNT_MAX      = DEF_CNT_MAX,
  parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int REPEAT_EN    = DEF_REPEAT_EN
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_posedge,
  output logic [N_KEYS-1:0] key_negedge,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int PW = cnt_width(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX     (CNT_MAX),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_EN   (REPEAT_EN)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key_raw    (key_in[i]),
      .tick       (tick),
      .key_level  (key_level[i]),
      .key_posedge(key_posedge[i]),
      .key_negedge(key_negedge[i]),
      .key_long   (key_long[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule
